// File: rtl/fetch.sv
// ---------------------------------------------------------------------------
// fetch -- instruction-fetch (IF) stage
//
// Generates sequential PCs, issues them on a req/gnt/rvalid instruction
// memory port, buffers returned words in a small FIFO and drives the IF/ID
// pipeline register consumed by decode. Honours stall/flush from the
// pipeline and redirects (branch/jump/trap) from EX, dropping any responses
// that belong to the stream that was abandoned.
//
// Ports:
//   clk_i          clock
//   rstn_i         asynchronous active-low reset
//   imem_req_o     fetch request
//   imem_addr_o    fetch address (word aligned)
//   imem_gnt_i     request accepted this cycle
//   imem_rvalid_i  response valid (in order, earliest the cycle after gnt)
//   imem_rdata_i   returned instruction word
//   redirect_i     change of flow from EX
//   target_i       redirect address (low two bits ignored)
//   stall_i        hold IF/ID contents
//   flush_i        load a bubble into IF/ID
//   instr_o        IF/ID instruction
//   pc_o           IF/ID PC
//   valid_o        IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module fetch #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] target_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        valid_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0]   LIMIT   = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [PW-1:0] LASTPTR = PW'(DEPTH - 1);

    logic [31:0]   r_fetchPc;
    logic [31:0]   r_respPc;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_rdPtr;
    logic [PW-1:0] r_wrPtr;
    logic [31:0]   r_fifoInstr [DEPTH];
    logic [31:0]   r_fifoPc    [DEPTH];
    logic [31:0]   r_instr;
    logic [31:0]   r_pc;
    logic          r_valid;

    logic [CW:0]   w_inFlight;
    logic [31:0]   w_target;
    logic          w_req;
    logic          w_grant;
    logic          w_retire;
    logic          w_keep;
    logic          w_load;
    logic          w_pop;
    logic          w_bypass;
    logic          w_push;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == LASTPTR) ? '0 : p + 1'b1;
    endfunction

    // Credit rule: words in flight plus words buffered never exceed the FIFO
    // depth, so every response is guaranteed a slot. Requests are suppressed
    // during reset and in the redirect cycle.
    assign w_inFlight = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_req      = rstn_i && !redirect_i && (w_inFlight < LIMIT);
    assign w_grant    = w_req && imem_gnt_i;
    assign w_target   = target_i & 32'hFFFF_FFFC;

    // A response is kept only if it belongs to the current stream; in a
    // redirect cycle any arriving word is stale by definition.
    assign w_retire = imem_rvalid_i && (r_outstanding != '0);
    assign w_keep   = imem_rvalid_i && !redirect_i && (r_discard == '0);
    assign w_load   = !stall_i && !flush_i && !redirect_i;
    assign w_pop    = w_load && (r_count != '0);
    assign w_bypass = w_keep && w_load && (r_count == '0);
    assign w_push   = w_keep && !w_bypass;

    assign imem_req_o  = w_req;
    assign imem_addr_o = r_fetchPc;
    assign instr_o     = r_instr;
    assign pc_o        = r_pc;
    assign valid_o     = r_valid;

    // PC tracking and the outstanding/discard bookkeeping. On redirect the
    // discard count becomes everything still in flight except a word that
    // retires in this very cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_fetchPc     <= BOOT_ADDR;
            r_respPc      <= BOOT_ADDR;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            if (redirect_i) begin
                r_fetchPc <= w_target;
                r_respPc  <= w_target;
                r_discard <= r_outstanding - CW'(w_retire);
            end else begin
                if (w_grant) r_fetchPc <= r_fetchPc + 32'd4;
                if (w_keep)  r_respPc  <= r_respPc + 32'd4;
                if (imem_rvalid_i && (r_discard != '0)) r_discard <= r_discard - 1'b1;
            end
            r_outstanding <= r_outstanding + CW'(w_grant) - CW'(w_retire);
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (redirect_i) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= nextPtr(r_wrPtr);
            if (w_pop)  r_rdPtr <= nextPtr(r_rdPtr);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // FIFO storage needs no reset; occupancy decides what is meaningful.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifoInstr[r_wrPtr] <= imem_rdata_i;
            r_fifoPc[r_wrPtr]    <= r_respPc;
        end
    end

    // IF/ID register: redirect/flush bubble, stall hold, then FIFO head,
    // then a bypassed fresh response, else a bubble keeping the old PC.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (redirect_i || flush_i) begin
            r_instr <= NOP_INSTR;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (!stall_i) begin
            if (r_count != '0) begin
                r_instr <= r_fifoInstr[r_rdPtr];
                r_pc    <= r_fifoPc[r_rdPtr];
                r_valid <= 1'b1;
            end else if (w_bypass) begin
                r_instr <= imem_rdata_i;
                r_pc    <= r_respPc;
                r_valid <= 1'b1;
            end else begin
                r_instr <= NOP_INSTR;
                r_valid <= 1'b0;
            end
        end
    end

    // The credit rule makes a response into a full FIFO a protocol error.
    a_noOverflow: assert property (@(posedge clk_i) disable iff (!rstn_i)
        !(imem_rvalid_i && (r_count == FULL)));

endmodule

// File: tb/tb_fetch.sv
// ---------------------------------------------------------------------------
// tb_fetch -- self-checking bench for the fetch stage
//
// A table of per-cycle memory/pipeline inputs with hand-computed outputs
// covers streaming, stall, flush and both redirect cases; a reactive memory
// with a two-cycle grant delay and three-cycle read latency then exercises
// address stability, bubbles and PC wrap-around.
// ---------------------------------------------------------------------------
module tb_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int NVEC = 27;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] target_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_o;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        stall;
        logic        flush;
        logic        redir;
        logic [31:0] target;
        logic        expReq;
        logic [31:0] expAddr;
        logic [31:0] expInstr;
        logic [31:0] expPc;
        logic        expValid;
    } vec_t;

    vec_t vecs [NVEC];

    fetch #(
        .BOOT_ADDR(32'h0000_0000),
        .DEPTH(2),
        .NOP_INSTR(NOP)
    ) dut (
        .clk_i(clk_i),
        .rstn_i(rstn_i),
        .imem_req_o(imem_req_o),
        .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i),
        .redirect_i(redirect_i),
        .target_i(target_i),
        .stall_i(stall_i),
        .flush_i(flush_i),
        .instr_o(instr_o),
        .pc_o(pc_o),
        .valid_o(valid_o)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input logic gnt, input logic rv, input logic [31:0] rdata,
                                input logic stall, input logic flush, input logic redir,
                                input logic [31:0] target, input logic expReq,
                                input logic [31:0] expAddr, input logic [31:0] expInstr,
                                input logic [31:0] expPc, input logic expValid);
        vec_t v;
        v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.stall = stall; v.flush = flush;
        v.redir = redir; v.target = target; v.expReq = expReq; v.expAddr = expAddr;
        v.expInstr = expInstr; v.expPc = expPc; v.expValid = expValid;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        imem_gnt_i    = v.gnt;
        imem_rvalid_i = v.rv;
        imem_rdata_i  = v.rdata;
        stall_i       = v.stall;
        flush_i       = v.flush;
        redirect_i    = v.redir;
        target_i      = v.target;
    endtask

    // Holds reset for a few cycles with a willing memory, checks the reset
    // state and releases on a falling edge.
    task automatic applyReset();
        rstn_i        = 1'b0;
        imem_gnt_i    = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        redirect_i    = 1'b0;
        target_i      = '0;
        stall_i       = 1'b0;
        flush_i       = 1'b0;
        repeat (3) @(negedge clk_i);
        checkOutput("rstReq", {31'b0, imem_req_o}, 32'd0);
        checkOutput("rstInstr", instr_o, NOP);
        checkOutput("rstPc", pc_o, 32'd0);
        checkOutput("rstValid", {31'b0, valid_o}, 32'd0);
        imem_gnt_i = 1'b0;
        rstn_i     = 1'b1;
    endtask

    initial begin
        // Per-cycle vectors: gnt rv rdata stall flush redir target | req addr instr pc valid
        vecs[0]  = mk(1,0,32'h00,  0,0,0,32'h0,   1,32'h00, NOP,  32'h0,  0);
        vecs[1]  = mk(1,1,32'h00,  0,0,0,32'h0,   1,32'h04, NOP,  32'h0,  0);
        vecs[2]  = mk(1,1,32'h04,  0,0,0,32'h0,   1,32'h08, 32'h00, 32'h00, 1);
        vecs[3]  = mk(1,1,32'h08,  0,0,0,32'h0,   1,32'h0C, 32'h04, 32'h04, 1);
        vecs[4]  = mk(1,1,32'h0C,  1,0,0,32'h0,   1,32'h10, 32'h08, 32'h08, 1);
        vecs[5]  = mk(1,1,32'h10,  1,0,0,32'h0,   0,32'h14, 32'h08, 32'h08, 1);
        vecs[6]  = mk(1,0,32'h00,  1,0,0,32'h0,   0,32'h14, 32'h08, 32'h08, 1);
        vecs[7]  = mk(1,0,32'h00,  0,0,0,32'h0,   0,32'h14, 32'h08, 32'h08, 1);
        vecs[8]  = mk(1,0,32'h00,  0,0,0,32'h0,   1,32'h14, 32'h0C, 32'h0C, 1);
        vecs[9]  = mk(1,1,32'h14,  0,0,0,32'h0,   1,32'h18, 32'h10, 32'h10, 1);
        vecs[10] = mk(1,1,32'h18,  0,0,0,32'h0,   1,32'h1C, 32'h14, 32'h14, 1);
        vecs[11] = mk(1,1,32'h1C,  1,0,0,32'h0,   1,32'h20, 32'h18, 32'h18, 1);
        vecs[12] = mk(1,1,32'h20,  0,1,0,32'h0,   0,32'h24, 32'h18, 32'h18, 1);
        vecs[13] = mk(1,0,32'h00,  0,0,0,32'h0,   0,32'h24, NOP,  32'h0,  0);
        vecs[14] = mk(1,0,32'h00,  0,0,0,32'h0,   1,32'h24, 32'h1C, 32'h1C, 1);
        vecs[15] = mk(1,1,32'h24,  0,0,0,32'h0,   1,32'h28, 32'h20, 32'h20, 1);
        vecs[16] = mk(1,0,32'h00,  0,0,0,32'h0,   1,32'h2C, 32'h24, 32'h24, 1);
        vecs[17] = mk(1,0,32'h00,  0,0,1,32'h103, 0,32'h30, NOP,  32'h0,  0);
        vecs[18] = mk(1,1,32'h28,  0,0,0,32'h0,   0,32'h100,NOP,  32'h0,  0);
        vecs[19] = mk(1,1,32'h2C,  0,0,0,32'h0,   1,32'h100,NOP,  32'h0,  0);
        vecs[20] = mk(1,1,32'h100, 0,0,0,32'h0,   1,32'h104,NOP,  32'h0,  0);
        vecs[21] = mk(0,1,32'h104, 0,0,0,32'h0,   1,32'h108,32'h100,32'h100,1);
        vecs[22] = mk(1,0,32'h00,  0,0,0,32'h0,   1,32'h108,32'h104,32'h104,1);
        vecs[23] = mk(1,1,32'h108, 0,0,1,32'h200, 0,32'h10C,NOP,  32'h0,  0);
        vecs[24] = mk(1,0,32'h00,  0,0,0,32'h0,   1,32'h200,NOP,  32'h0,  0);
        vecs[25] = mk(0,1,32'h200, 0,0,0,32'h0,   1,32'h204,NOP,  32'h0,  0);
        vecs[26] = mk(0,0,32'h00,  0,0,0,32'h0,   1,32'h204,32'h200,32'h200,1);

        applyReset();

        // Table phase: drive on the falling edge, check one step later.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk_i);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d.req", i), {31'b0, imem_req_o}, {31'b0, vecs[i].expReq});
            checkOutput($sformatf("v%0d.addr", i), imem_addr_o, vecs[i].expAddr);
            checkOutput($sformatf("v%0d.instr", i), instr_o, vecs[i].expInstr);
            checkOutput($sformatf("v%0d.valid", i), {31'b0, valid_o}, {31'b0, vecs[i].expValid});
            if (vecs[i].expValid)
                checkOutput($sformatf("v%0d.pc", i), pc_o, vecs[i].expPc);
        end

        // Slow memory around the top of the address space: redirect to
        // 0xFFFF_FFF8, then grant each request on its third cycle and
        // return data three cycles after the grant.
        applyReset();
        @(negedge clk_i);
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        redirect_i    = 1'b1;
        target_i      = 32'hFFFF_FFF8;
        #1;
        checkOutput("redirReq", {31'b0, imem_req_o}, 32'd0);

        begin
            logic [31:0] addrQ [$];
            int          dueQ  [$];
            logic [31:0] heldAddr = '0;
            logic [31:0] expPc    = 32'hFFFF_FFF8;
            int          reqAge   = 0;
            int          got      = 0;
            for (int cyc = 0; cyc < 80 && got < 4; cyc++) begin
                @(negedge clk_i);
                redirect_i    = 1'b0;
                target_i      = '0;
                imem_gnt_i    = 1'b0;
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = '0;
                if (dueQ.size() > 0 && dueQ[0] == cyc) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = addrQ[0];
                    void'(dueQ.pop_front());
                    void'(addrQ.pop_front());
                end
                #1;
                if (imem_req_o) begin
                    if (reqAge > 0) checkOutput("addrStable", imem_addr_o, heldAddr);
                    heldAddr = imem_addr_o;
                    reqAge++;
                    if (reqAge == 3) begin
                        imem_gnt_i = 1'b1;
                        dueQ.push_back(cyc + 3);
                        addrQ.push_back(imem_addr_o);
                        reqAge = 0;
                    end
                end else begin
                    reqAge = 0;
                end
                if (valid_o) begin
                    checkOutput("wrapPc", pc_o, expPc);
                    checkOutput("wrapInstr", instr_o, expPc);
                    expPc = expPc + 32'd4;
                    got++;
                end else begin
                    checkOutput("bubbleNop", instr_o, NOP);
                end
            end
            checkOutput("wrapCount", got, 32'd4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction-fetch (IF) stage; sits directly upstream of the decode stage.
- Generates sequential PCs and issues requests on a req/gnt/rvalid instruction-memory port.
- Buffers returned words in a small FIFO and drives the IF/ID pipeline register (instruction and PC) consumed by decode.
- Honours pipeline stall/flush and branch/jump/trap redirects from EX, discarding stale in-flight responses.

Parameters:
BOOT_ADDR  32'h0000_0000  PC after reset; low 2 bits must be 0
DEPTH  2  instruction FIFO entries; also max outstanding + buffered words (>=1)
NOP_INSTR  32'h0000_0013  bubble instruction (addi x0,x0,0)

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
imem_req_o  out  1  fetch request
imem_addr_o  out  32  fetch address, word aligned
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response data valid; in order, earliest the cycle after gnt
imem_rdata_i  in  32  instruction word
redirect_i  in  1  change of flow from EX
target_i  in  32  redirect address; bits [1:0] ignored (treated 0)
stall_i  in  1  hold IF/ID contents
flush_i  in  1  load bubble into IF/ID
instr_o  out  32  IF/ID instruction (to decode instr_i)
pc_o  out  32  IF/ID PC (to decode pc_i)
valid_o  out  1  IF/ID holds a real instruction

Behaviour:
- Reset, async on rstn_i low:
  - fetch_pc = BOOT_ADDR, resp_pc = BOOT_ADDR; FIFO empty; outstanding = 0, discard = 0.
  - instr_o = NOP_INSTR, pc_o = 0, valid_o = 0.
  - imem_req_o = 0 while in reset.
  - Reset mid-transaction drops all state; responses arriving after reset release are not expected (memory is reset too).
- Request side:
  - imem_req_o = !redirect_i && (outstanding + fifo_count < DEPTH).
  - imem_addr_o = fetch_pc.
  - On req && gnt: fetch_pc += 4 (32-bit wrap at 0xFFFF_FFFC -> 0), outstanding += 1.
  - req may deassert without a grant; the address may change only on redirect.
- Response side, on each imem_rvalid_i:
  - outstanding -= 1.
  - If discard > 0: drop the word, discard -= 1.
  - Otherwise tag the word with resp_pc, then resp_pc += 4.
  - If the FIFO is empty and the IF/ID register loads this cycle (!stall_i, !flush_i, !redirect_i), bypass the word straight into IF/ID (1-cycle latency from rvalid to instr_o). Otherwise push it to the FIFO.
  - The credit rule guarantees the FIFO never overflows. An rvalid arriving while the FIFO is full is an assertion error.
- IF/ID register, priority redirect_i > flush_i > stall_i:
  - redirect_i or flush_i: instr_o = NOP_INSTR, pc_o = 0, valid_o = 0.
  - stall_i: hold all; no FIFO pop. Responses still fill the FIFO.
  - Otherwise, FIFO non-empty: pop head into instr_o/pc_o, valid_o = 1.
  - Otherwise, bypassed response if present.
  - Otherwise bubble (NOP_INSTR, pc_o unchanged-don't-care, valid_o = 0).
- Redirect (single cycle):
  - fetch_pc <= {target_i[31:2],2'b00}, resp_pc <= same; FIFO cleared.
  - discard <= outstanding minus 1 if rvalid in this cycle (that word is dropped).
  - No grant is possible in the redirect cycle (req forced 0).
  - First request at target issues the next cycle.
  - A second redirect while discard > 0 adds nothing; discard still counts only old-stream words.
- Counters: outstanding and discard are $clog2(DEPTH+1) bits; neither underflows.
- No reordering; responses match grants in order.

Test Plan:
- Reset release, memory gnt=1 each cycle, rvalid 1 cycle after gnt, rdata=addr -> instr_o/pc_o = 0x0,0x4,0x8... on consecutive cycles, valid_o=1 from cycle 3, imem_addr_o never exceeds 2 outstanding.
- stall_i high 3 cycles during streaming -> instr_o/pc_o held, FIFO fills to 2, req_o drops to 0; after release, next instrs 0x..+4, +8 with no gap or loss.
- redirect_i to 0x100 with 2 outstanding requests -> both responses dropped, valid_o=0 meanwhile, next valid instr_o has pc_o=0x100; target 0x103 -> fetch at 0x100.
- redirect_i and rvalid_i in the same cycle with 1 outstanding -> word dropped, discard stays 0, next valid pc_o = target.
- flush_i with FIFO non-empty and no redirect -> IF/ID bubble (NOP, valid_o=0) for one cycle, FIFO contents preserved, following pc_o continues sequentially.
- Memory with gnt delayed 2 cycles and rvalid latency 3 -> addr stable while req pending, in-order PCs, bubbles (valid_o=0, instr_o=0x13) in gaps; fetch_pc wrap from 0xFFFF_FFFC -> 0x0.
